hazard_scoreboard: RTL and testbench
====================================

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

Interface
REQ-001 Parameter REG_W, default 5: register-specifier width in bits.
REQ-002 Parameter DEPTH, default 4: number of in-flight destination entries (pipeline stages tracked); legal range 2..8.
REQ-003 Parameter NSRC, default 2: number of source specifiers compared per cycle.
REQ-004 Parameter R0_ZERO, default 1: when 1, specifier 0 is never recorded and never matches.
REQ-005 Ports: clk, input, 1, sole clock; all state on its rising edge.
REQ-006 Ports: rst_n, input, 1, asynchronous active-low reset.
REQ-007 Ports: issue_valid, input, 1, instruction entering the tracked pipeline this cycle.
REQ-008 Ports: issue_wr, input, 1, the issuing instruction writes a register.
REQ-009 Ports: issue_load, input, 1, the issuing instruction's result is available only at stage 1 or later (load).
REQ-010 Ports: issue_dst, input, REG_W, the issuing instruction's destination specifier.
REQ-011 Ports: advance, input, 1, pipeline moves one stage this cycle.
REQ-012 Ports: flush, input, 1, squash the youngest entry.
REQ-013 Ports: src_addr, input, NSRC*REG_W, packed source specifiers; source s in bits [s*REG_W +: REG_W].
REQ-014 Ports: src_used, input, NSRC, per-source enable.
REQ-015 Ports: hit, output, NSRC, source s matches a valid entry.
REQ-016 Ports: fwd_idx, output, NSRC*clog2(DEPTH), packed index of the youngest matching entry per source.
REQ-017 Ports: stall, output, 1, load-use hazard present.
REQ-018 Ports: occupancy, output, clog2(DEPTH+1), registered count of valid entries.

Function
REQ-019 Entries e[0..DEPTH-1] SHALL each hold valid, dst and is_load; e[0] is youngest.
REQ-020 When advance=1, e[i+1] SHALL take e[i] for all i, and e[DEPTH-1]'s contents are discarded.
REQ-021 When advance=1, e[0].valid SHALL take issue_valid & issue_wr & !flush & !(R0_ZERO & issue_dst==0).
REQ-022 When advance=1, e[0].dst SHALL take issue_dst and e[0].is_load SHALL take issue_load.
REQ-023 When advance=0, all entries SHALL hold their values, and flush=1 SHALL clear only e[0].valid.
REQ-024 issue_* inputs SHALL be ignored when advance=0.
REQ-025 hit[s] SHALL equal src_used[s] & OR over i of (e[i].valid & e[i].dst==src[s]), gated by the R0_ZERO rule; it is combinational, zero latency.
REQ-026 fwd_idx[s] SHALL be the lowest i that matches (youngest wins), and SHALL be 0 when hit[s]=0.
REQ-027 stall SHALL be 1 iff, for some s, hit[s]=1 and fwd_idx[s]=0 and e[0].is_load=1; it is combinational.
REQ-028 occupancy SHALL always equal the population count of entry valid bits after each edge, maintained as a registered counter.
REQ-029 Simultaneous advance and flush SHALL shift, with a bubble inserted at e[0].

Reset
REQ-030 On rst_n=0, all entry valid bits and occupancy SHALL clear immediately, without waiting for a clock edge; dst and is_load are don't-care.
REQ-031 While reset is held, hit, fwd_idx and stall SHALL be 0.
REQ-032 Deassertion SHALL be synchronised externally; reset mid-operation discards all entries.

Structure
REQ-033 A shared package SHALL hold the entry struct (valid, dst, is_load) and the index-width helper constant.
REQ-034 One sub-module SHALL be used: scoreboard_match, a per-source DEPTH-way comparator plus youngest-first priority encoder, instantiated NSRC times.

Verification
REQ-035 Reset, then issue dst=3 (not a load) with advance; next cycle with src0=3 -> hit[0]=1, fwd_idx[0]=0, stall=0, occupancy=1.
REQ-036 Issue a load to dst=7, then src1=7 in the following cycle -> stall=1; after one more advance with a bubble, stall=0 and fwd_idx[1]=1.
REQ-037 Write dst=5 at two consecutive cycles -> fwd_idx=0 (youngest); after DEPTH+1 bubbles -> hit=0 and occupancy=0.
REQ-038 With R0_ZERO=1, issue dst=0 -> occupancy unchanged; src0=0 -> hit[0]=0.
REQ-039 Check flush in two cases: with advance=0, e[0] is cleared and e[1..] are kept; with advance=1 and issue dst=9, the shift occurs and dst=9 is not recorded.
REQ-040 Assert rst_n low mid-stream with 4 valid entries -> occupancy=0 and hit=0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types and helpers for the register hazard scoreboard.
package hazard_scoreboard_pkg;

    // Widest register specifier an entry can hold; narrower specifiers are zero-extended.
    localparam int SB_MAX_REG_W = 16;

    // Largest supported number of tracked stages.
    localparam int SB_MAX_DEPTH = 8;

    // One in-flight destination: valid flag, destination specifier, late-result marker.
    typedef struct packed {
        logic                    valid;
        logic [SB_MAX_REG_W-1:0] dst;
        logic                    isLoad;
    } sbEntry_t;

    // Bits needed to name an entry index; at least one bit even for tiny depths.
    function automatic int idxWidth(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/hazard_scoreboard_match.sv
// Per-source comparator: checks one source specifier against every tracked
// entry and reports the youngest (lowest index) match.
module scoreboard_match
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_W   = 5,
    parameter int DEPTH   = 4,
    parameter int R0_ZERO = 1,
    parameter int IDX_W   = 2
) (
    input  sbEntry_t               entries [DEPTH],
    input  logic     [REG_W-1:0]   src,
    input  logic                   used,
    output logic                   hit,
    output logic     [IDX_W-1:0]   idx
);

    logic srcIsZeroReg;

    // Specifier 0 is a hardwired zero register when R0_ZERO is set; it never matches.
    always_comb begin
        srcIsZeroReg = (R0_ZERO != 0) && (src == '0);
    end

    // Scan oldest to youngest so the last assignment, the youngest match, wins.
    always_comb begin
        hit = 1'b0;
        idx = '0;
        if (used && !srcIsZeroReg) begin
            for (int i = DEPTH - 1; i >= 0; i--) begin
                if (entries[i].valid && (entries[i].dst == SB_MAX_REG_W'(src))) begin
                    hit = 1'b1;
                    idx = IDX_W'(i);
                end
            end
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Hazard scoreboard: a shift register of in-flight destination registers,
// with per-source forwarding lookup and load-use stall detection.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_W   = 5,
    parameter int DEPTH   = 4,
    parameter int NSRC    = 2,
    parameter int R0_ZERO = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                issue_valid,
    input  logic                                issue_wr,
    input  logic                                issue_load,
    input  logic [REG_W-1:0]                    issue_dst,
    input  logic                                advance,
    input  logic                                flush,
    input  logic [NSRC*REG_W-1:0]               src_addr,
    input  logic [NSRC-1:0]                     src_used,
    output logic [NSRC-1:0]                     hit,
    output logic [NSRC*idxWidth(DEPTH)-1:0]     fwd_idx,
    output logic                                stall,
    output logic [$clog2(DEPTH+1)-1:0]          occupancy
);

    localparam int IDX_W = idxWidth(DEPTH);
    localparam int OCC_W = $clog2(DEPTH + 1);

    // Entry state, index 0 is the youngest. Only the valid bits are reset;
    // dst/isLoad are meaningless while their valid bit is clear.
    logic [DEPTH-1:0] entValid;
    logic [REG_W-1:0] entDst  [DEPTH];
    logic             entLoad [DEPTH];
    sbEntry_t         entView [DEPTH];

    logic             newValid;
    logic [OCC_W-1:0] occNext;

    // An issuing instruction is recorded only if it writes a real register and is not squashed.
    always_comb begin
        newValid = issue_valid && issue_wr && !flush
                   && !((R0_ZERO != 0) && (issue_dst == '0));
    end

    // Valid bits shift on advance (bubble on flush); without advance, flush kills only the youngest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entValid <= '0;
        end else if (advance) begin
            entValid <= {entValid[DEPTH-2:0], newValid};
        end else if (flush) begin
            entValid[0] <= 1'b0;
        end
    end

    // Payload shifts alongside the valid bits; issue inputs are captured only on advance.
    always_ff @(posedge clk) begin
        if (advance) begin
            entDst[0]  <= issue_dst;
            entLoad[0] <= issue_load;
            for (int i = 1; i < DEPTH; i++) begin
                entDst[i]  <= entDst[i-1];
                entLoad[i] <= entLoad[i-1];
            end
        end
    end

    // Incremental occupancy update: one entry may enter and one may leave per cycle.
    always_comb begin
        occNext = occupancy;
        if (advance) begin
            occNext = occupancy + OCC_W'(newValid) - OCC_W'(entValid[DEPTH-1]);
        end else if (flush && entValid[0]) begin
            occNext = occupancy - OCC_W'(1);
        end
    end

    // Registered valid-entry count, cleared together with the valid bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occupancy <= '0;
        end else begin
            occupancy <= occNext;
        end
    end

    // Package-typed view of the entries for the comparators.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entView[i].valid  = entValid[i];
            entView[i].dst    = SB_MAX_REG_W'(entDst[i]);
            entView[i].isLoad = entLoad[i];
        end
    end

    for (genvar s = 0; s < NSRC; s++) begin : gSrc
        scoreboard_match #(
            .REG_W  (REG_W),
            .DEPTH  (DEPTH),
            .R0_ZERO(R0_ZERO),
            .IDX_W  (IDX_W)
        ) uMatch (
            .entries(entView),
            .src    (src_addr[s*REG_W +: REG_W]),
            .used   (src_used[s]),
            .hit    (hit[s]),
            .idx    (fwd_idx[s*IDX_W +: IDX_W])
        );
    end

    // Load-use hazard: a source needs the youngest entry and that entry is a load.
    always_comb begin
        stall = 1'b0;
        for (int s = 0; s < NSRC; s++) begin
            if (hit[s] && (fwd_idx[s*IDX_W +: IDX_W] == '0) && entLoad[0]) begin
                stall = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: stimulus queues expected outputs,
// a negedge monitor pops and compares them.
module tb_hazard_scoreboard;

    localparam int REG_W   = 5;
    localparam int DEPTH   = 4;
    localparam int NSRC    = 2;
    localparam int R0_ZERO = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       issue_valid, issue_wr, issue_load;
    logic [4:0] issue_dst;
    logic       advance, flush;
    logic [9:0] src_addr;
    logic [1:0] src_used;
    logic [1:0] hit;
    logic [3:0] fwd_idx;
    logic       stall;
    logic [2:0] occupancy;

    typedef struct {
        string      name;
        logic [1:0] hit;
        logic [1:0] fwd0;
        logic [1:0] fwd1;
        logic       stall;
        logic [2:0] occ;
    } exp_t;

    exp_t expQ[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    hazard_scoreboard #(
        .REG_W  (REG_W),
        .DEPTH  (DEPTH),
        .NSRC   (NSRC),
        .R0_ZERO(R0_ZERO)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .issue_valid(issue_valid),
        .issue_wr   (issue_wr),
        .issue_load (issue_load),
        .issue_dst  (issue_dst),
        .advance    (advance),
        .flush      (flush),
        .src_addr   (src_addr),
        .src_used   (src_used),
        .hit        (hit),
        .fwd_idx    (fwd_idx),
        .stall      (stall),
        .occupancy  (occupancy)
    );

    task automatic cmp(input string name, input string field, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s actual=%0h required=%0h", name, field, act, req);
        end
    endtask

    // Monitor: compare every queued expectation against the outputs at the falling edge.
    always @(negedge clk) begin
        exp_t e;
        while (expQ.size() > 0) begin
            e = expQ.pop_front();
            cmp(e.name, "hit",   8'(hit),           8'(e.hit));
            cmp(e.name, "fwd0",  8'(fwd_idx[1:0]),  8'(e.fwd0));
            cmp(e.name, "fwd1",  8'(fwd_idx[3:2]),  8'(e.fwd1));
            cmp(e.name, "stall", 8'(stall),         8'(e.stall));
            cmp(e.name, "occ",   8'(occupancy),     8'(e.occ));
        end
    end

    task automatic setIn(input logic adv, input logic iv, input logic wr, input logic ld,
                         input logic [4:0] dst, input logic fl,
                         input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used);
        advance     = adv;
        issue_valid = iv;
        issue_wr    = wr;
        issue_load  = ld;
        issue_dst   = dst;
        flush       = fl;
        src_addr    = {s1, s0};
        src_used    = used;
    endtask

    task automatic push(input string n, input logic [1:0] h, input logic [1:0] f0,
                        input logic [1:0] f1, input logic st, input logic [2:0] oc);
        exp_t e;
        e.name  = n;
        e.hit   = h;
        e.fwd0  = f0;
        e.fwd1  = f1;
        e.stall = st;
        e.occ   = oc;
        expQ.push_back(e);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle: expectations describe the current state with these sources,
    // issue/advance/flush take effect at the following rising edge.
    task automatic step(input logic adv, input logic iv, input logic wr, input logic ld,
                        input logic [4:0] dst, input logic fl,
                        input logic [4:0] s0, input logic [4:0] s1, input logic [1:0] used,
                        input string n, input logic [1:0] h, input logic [1:0] f0,
                        input logic [1:0] f1, input logic st, input logic [2:0] oc);
        setIn(adv, iv, wr, ld, dst, fl, s0, s1, used);
        push(n, h, f0, f1, st, oc);
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b1;
        setIn(0, 0, 0, 0, 5'd0, 0, 5'd3, 5'd0, 2'b01);
        #2 rst_n = 1'b0;
        push("reset_hold", 2'b00, 2'd0, 2'd0, 1'b0, 3'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Single non-load write, then lookup.
        step(1, 1, 1, 0, 5'd3, 0, 5'd3, 5'd0, 2'b01, "r035_pre",   2'b00, 2'd0, 2'd0, 1'b0, 3'd0);
        step(0, 0, 0, 0, 5'd0, 0, 5'd3, 5'd0, 2'b01, "r035",       2'b01, 2'd0, 2'd0, 1'b0, 3'd1);

        // Load-use.
        step(1, 1, 1, 1, 5'd7, 0, 5'd3, 5'd7, 2'b11, "r036_pre",   2'b01, 2'd0, 2'd0, 1'b0, 3'd1);
        step(1, 0, 0, 0, 5'd0, 0, 5'd3, 5'd7, 2'b11, "r036_stall", 2'b11, 2'd1, 2'd0, 1'b1, 3'd2);
        step(0, 0, 0, 0, 5'd0, 0, 5'd3, 5'd7, 2'b11, "r036_after", 2'b11, 2'd2, 2'd1, 1'b0, 3'd2);

        // Same destination twice: youngest wins, then drain.
        step(1, 1, 1, 0, 5'd5, 0, 5'd5, 5'd0, 2'b01, "r037_pre",   2'b00, 2'd0, 2'd0, 1'b0, 3'd2);
        step(1, 1, 1, 0, 5'd5, 0, 5'd5, 5'd0, 2'b01, "r037_first", 2'b01, 2'd0, 2'd0, 1'b0, 3'd3);
        step(0, 0, 0, 0, 5'd0, 0, 5'd5, 5'd7, 2'b11, "r037_young", 2'b11, 2'd0, 2'd3, 1'b0, 3'd3);
        for (int i = 0; i < DEPTH + 1; i++) begin
            setIn(1, 0, 0, 0, 5'd0, 0, 5'd0, 5'd0, 2'b00);
            tick();
        end
        step(0, 0, 0, 0, 5'd0, 0, 5'd5, 5'd5, 2'b11, "r037_drain", 2'b00, 2'd0, 2'd0, 1'b0, 3'd0);

        // Register zero is never recorded nor matched.
        step(1, 1, 1, 0, 5'd2, 0, 5'd0, 5'd0, 2'b00, "r038_pre",   2'b00, 2'd0, 2'd0, 1'b0, 3'd0);
        step(1, 1, 1, 0, 5'd0, 0, 5'd2, 5'd0, 2'b01, "r038_mid",   2'b01, 2'd0, 2'd0, 1'b0, 3'd1);
        step(0, 0, 0, 0, 5'd0, 0, 5'd0, 5'd2, 2'b11, "r038_zero",  2'b10, 2'd0, 2'd1, 1'b0, 3'd1);

        // Flush without advance (issue ignored), then flush with advance.
        step(1, 1, 1, 1, 5'd4, 0, 5'd0, 5'd0, 2'b00, "r039_pre",   2'b00, 2'd0, 2'd0, 1'b0, 3'd1);
        step(0, 1, 1, 0, 5'd6, 1, 5'd4, 5'd2, 2'b11, "r039_pre2",  2'b11, 2'd0, 2'd2, 1'b1, 3'd2);
        step(0, 0, 0, 0, 5'd0, 0, 5'd4, 5'd2, 2'b11, "r039_hold",  2'b10, 2'd0, 2'd2, 1'b0, 3'd1);
        step(0, 0, 0, 0, 5'd0, 0, 5'd6, 5'd2, 2'b11, "r039_ign",   2'b10, 2'd0, 2'd2, 1'b0, 3'd1);
        step(1, 1, 1, 0, 5'd9, 1, 5'd9, 5'd2, 2'b11, "r039_advpre", 2'b10, 2'd0, 2'd2, 1'b0, 3'd1);
        step(0, 0, 0, 0, 5'd0, 0, 5'd9, 5'd2, 2'b11, "r039_advfl", 2'b10, 2'd0, 2'd3, 1'b0, 3'd1);

        // Fill all four entries, then reset asynchronously.
        for (int i = 0; i < DEPTH; i++) begin
            setIn(1, 1, 1, 0, 5'(10 + i), 0, 5'd0, 5'd0, 2'b00);
            tick();
        end
        step(0, 0, 0, 0, 5'd0, 0, 5'd10, 5'd13, 2'b11, "r040_full", 2'b11, 2'd3, 2'd0, 1'b0, 3'd4);
        rst_n = 1'b0;
        push("r040_async", 2'b00, 2'd0, 2'd0, 1'b0, 3'd0);
        tick();
        push("r040_held", 2'b00, 2'd0, 2'd0, 1'b0, 3'd0);
        tick();
        rst_n = 1'b1;

        // Normal operation resumes after reset.
        step(1, 1, 1, 0, 5'd3, 0, 5'd3, 5'd10, 2'b11, "post_pre",  2'b00, 2'd0, 2'd0, 1'b0, 3'd0);
        step(0, 0, 0, 0, 5'd0, 0, 5'd3, 5'd10, 2'b11, "post_hit",  2'b01, 2'd0, 2'd0, 1'b0, 3'd1);

        @(negedge clk);
        #1;
        cmp("end", "queue", 8'(expQ.size()), 8'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
